// File: rtl/sdram_bist.sv
// rtl/sdram_bist.sv - two-pass write/read-back self test driving the SDRAM controller request port
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               one-cycle pulse, accepted only in IDLE
//   busy, done, pass    test status; pass/timeout_err valid while done=1
//   timeout_err         test aborted because the controller stopped handshaking
//   err_count           saturating count of mismatching reads
//   first_err_addr/data address and read data of the first mismatch
//   mem_enable, mem_write, mem_addr, mem_write_data   request to the controller
//   mem_read_data, mem_ready                          response from the controller
module sdram_bist #(
  parameter int                 ADDR_W     = 24,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter int                 NUM_WORDS  = 1024,
  parameter int                 ADDR_STEP  = 1,
  parameter int                 TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  localparam int               CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [15:0]      TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, INIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] addr_cnt;
  logic             pass_sel;
  logic             ready_q;
  logic [15:0]      wd;

  logic              accept, complete, advance, watched, last;
  logic [ADDR_W-1:0] step_addr;

  // Pattern {A5, address}; pass 1 writes the complement so every bit toggles.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
    logic [DATA_W-1:0] p;
    p = '0;
    p[ADDR_W-1:0] = a;
    p[DATA_W-1 -: 8] = 8'hA5;
    return inv ? ~p : p;
  endfunction

  // Handshakes are edge-qualified so a ready glitch in REQ cannot count as completion.
  assign accept    = ready_q & ~mem_ready;
  assign complete  = ~ready_q & mem_ready;
  assign last      = (addr_cnt == LAST_CNT);
  assign step_addr = last ? START_ADDR : mem_addr + ADDR_W'(ADDR_STEP);

  always_comb begin
    advance = 1'b0;
    watched = 1'b1;
    unique case (state)
      INIT:             advance = mem_ready;
      WR_REQ, RD_REQ:   advance = accept;
      WR_WAIT, RD_WAIT: advance = complete;
      default:          watched = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_cnt       <= '0;
      pass_sel       <= 1'b0;
      ready_q        <= 1'b0;
      wd             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout_err    <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      mem_enable     <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      ready_q <= mem_ready;
      if (watched && !advance) begin
        if (wd == TO_LIMIT) begin
          timeout_err <= 1'b1;
          mem_enable  <= 1'b0;
          mem_write   <= 1'b0;
          wd          <= '0;
          state       <= FINISH;
        end else begin
          wd <= wd + 16'd1;
        end
      end else begin
        wd <= '0;
        unique case (state)
          IDLE: if (start) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pass           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            busy           <= 1'b1;
            addr_cnt       <= '0;
            pass_sel       <= 1'b0;
            state          <= INIT;
          end
          INIT: begin
            mem_enable     <= 1'b1;
            mem_write      <= 1'b1;
            mem_addr       <= START_ADDR;
            mem_write_data <= pattern(START_ADDR, 1'b0);
            state          <= WR_REQ;
          end
          WR_REQ, RD_REQ: begin
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            state      <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
          end
          WR_WAIT: begin
            addr_cnt       <= last ? '0 : addr_cnt + CNT_W'(1);
            mem_enable     <= 1'b1;
            mem_write      <= ~last;
            mem_addr       <= step_addr;
            mem_write_data <= pattern(step_addr, pass_sel);
            state          <= last ? RD_REQ : WR_REQ;
          end
          RD_WAIT: begin
            // mem_write_data still holds the expected pattern for this address.
            if (mem_read_data != mem_write_data) begin
              if (err_count == 16'h0000) begin
                first_err_addr <= mem_addr;
                first_err_data <= mem_read_data;
              end
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (last && pass_sel) begin
              state <= FINISH;
            end else begin
              addr_cnt       <= last ? '0 : addr_cnt + CNT_W'(1);
              pass_sel       <= pass_sel | last;
              mem_enable     <= 1'b1;
              mem_write      <= last;
              mem_addr       <= step_addr;
              mem_write_data <= pattern(step_addr, pass_sel | last);
              state          <= last ? WR_REQ : RD_REQ;
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'h0000) && !timeout_err;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_bist.sv
// tb/tb_sdram_bist.sv - directed self-checking bench for sdram_bist
module tb_sdram_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;
  int   sel;
  int   vectors, miscompares;

  logic [2:0]  start_v, busy, done, pass_o, to_err, en, wr;
  logic [15:0] ec   [3];
  logic [23:0] fea  [3];
  logic [23:0] addr [3];
  logic [31:0] fed  [3];
  logic [31:0] wdat [3];

  assign start_v = start ? 3'(1 << sel) : 3'b000;

  // Shared controller model serving whichever DUT is selected.
  typedef struct packed { logic wr; logic [23:0] addr; logic [31:0] data; } tx_t;
  tx_t         log_q[$];
  logic        m_ready, m_busy, m_hang, m_clr, m_wr;
  logic [23:0] m_addr;
  logic [31:0] m_rdata;
  logic [31:0] mem [256];
  int          m_cnt, n_wr;
  bit          stall_mode, stuck_mode, zero_mode;

  sdram_bist #(.START_ADDR(24'h000000), .NUM_WORDS(4), .TIMEOUT(20)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass_o[0]), .timeout_err(to_err[0]), .err_count(ec[0]),
    .first_err_addr(fea[0]), .first_err_data(fed[0]), .mem_enable(en[0]),
    .mem_write(wr[0]), .mem_addr(addr[0]), .mem_write_data(wdat[0]),
    .mem_read_data(m_rdata), .mem_ready(m_ready));

  sdram_bist #(.START_ADDR(24'hFFFFFE), .NUM_WORDS(4), .TIMEOUT(20)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass_o[1]), .timeout_err(to_err[1]), .err_count(ec[1]),
    .first_err_addr(fea[1]), .first_err_data(fed[1]), .mem_enable(en[1]),
    .mem_write(wr[1]), .mem_addr(addr[1]), .mem_write_data(wdat[1]),
    .mem_read_data(m_rdata), .mem_ready(m_ready));

  sdram_bist #(.START_ADDR(24'h000000), .NUM_WORDS(20), .TIMEOUT(20)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass_o[2]), .timeout_err(to_err[2]), .err_count(ec[2]),
    .first_err_addr(fea[2]), .first_err_data(fed[2]), .mem_enable(en[2]),
    .mem_write(wr[2]), .mem_addr(addr[2]), .mem_write_data(wdat[2]),
    .mem_read_data(m_rdata), .mem_ready(m_ready));

  // ready drops one cycle after enable, returns four cycles later with read data.
  always @(posedge clk) begin
    logic [31:0] d;
    if (m_clr) begin
      m_ready <= 1'b1; m_busy <= 1'b0; m_hang <= 1'b0; m_cnt <= 0; n_wr <= 0;
    end else if (m_busy) begin
      if (m_hang) begin
        m_ready <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end else begin
        m_ready <= 1'b1;
        m_busy  <= 1'b0;
        if (!m_wr) begin
          d = mem[m_addr[7:0]];
          if (zero_mode) d = 32'h0;
          else if (stuck_mode && m_addr == 24'd2) d[0] = 1'b0;
          m_rdata <= d;
        end
      end
    end else if (en[sel] && m_ready) begin
      m_ready <= 1'b0; m_busy <= 1'b1; m_cnt <= 3;
      m_wr <= wr[sel]; m_addr <= addr[sel];
      if (wr[sel]) begin
        mem[addr[sel][7:0]] <= wdat[sel];
        n_wr <= n_wr + 1;
        if (stall_mode && n_wr == 2) m_hang <= 1'b1;
      end
      log_q.push_back({wr[sel], addr[sel], wdat[sel]});
    end
  end

  task automatic model_reset;
    @(negedge clk); m_clr = 1'b1;
    @(negedge clk); m_clr = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[idx]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({busy[k], done[k], pass_o[k], to_err[k], en[k], wr[k]} !== 6'b0 ||
          ec[k] !== 16'h0 || fea[k] !== 24'h0 || fed[k] !== 32'h0 ||
          addr[k] !== 24'h0 || wdat[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset dut%0d: busy=%b done=%b en=%b ec=%h addr=%h, required all zero",
                 k, busy[k], done[k], en[k], ec[k], addr[k]);
      end
    end
  endtask

  task automatic test_clean;
    int base; bit ok; logic [23:0] a; logic [31:0] p; logic ew;
    sel = 0; model_reset; base = log_q.size();
    pulse_start; wait_done(0, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL clean_done: done=0, required 1 within 400 cycles"); end
    vectors++;
    if (log_q.size() - base !== 16) begin
      miscompares++; $display("FAIL clean_txn_count: got %0d, required 16", log_q.size() - base);
    end
    for (int i = 0; i < 16 && base + i < log_q.size(); i++) begin
      a  = 24'(i % 4);
      ew = ((i / 4) % 2) == 0;
      p  = 32'hA5000000 | {8'h00, a};
      if (i >= 8) p = ~p;
      vectors++;
      if (log_q[base+i].wr !== ew || log_q[base+i].addr !== a ||
          (ew && log_q[base+i].data !== p)) begin
        miscompares++;
        $display("FAIL clean_txn%0d: wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                 i, log_q[base+i].wr, log_q[base+i].addr, log_q[base+i].data, ew, a, p);
      end
    end
    vectors++;
    if ({done[0], pass_o[0], to_err[0], busy[0]} !== 4'b1100 || ec[0] !== 16'h0) begin
      miscompares++;
      $display("FAIL clean_status: done=%b pass=%b to=%b busy=%b ec=%h, required 1 1 0 0 0000",
               done[0], pass_o[0], to_err[0], busy[0], ec[0]);
    end
  endtask

  task automatic test_stuck_bit;
    bit ok;
    sel = 0; stuck_mode = 1'b1; model_reset;
    pulse_start; wait_done(0, 400, ok);
    stuck_mode = 1'b0;
    vectors++;
    if (!ok || pass_o[0] !== 1'b0 || ec[0] !== 16'd1) begin
      miscompares++;
      $display("FAIL stuck_count: done=%b pass=%b ec=%h, required 1 0 0001", done[0], pass_o[0], ec[0]);
    end
    vectors++;
    if (fea[0] !== 24'd2 || fed[0] !== 32'h5AFFFFFC) begin
      miscompares++;
      $display("FAIL stuck_first: addr=%h data=%h, required 000002 5afffffc", fea[0], fed[0]);
    end
  endtask

  task automatic test_timeout;
    int base, cyc; bit ok;
    sel = 0; stall_mode = 1'b1; model_reset; base = log_q.size();
    pulse_start; wait_log(base + 3, 200, ok);
    cyc = 0;
    while (cyc < 40 && !to_err[0]) begin @(negedge clk); cyc++; end
    vectors++;
    if (!ok || cyc < 20 || cyc > 22) begin
      miscompares++; $display("FAIL timeout_latency: %0d cycles after stall, required 20..22", cyc);
    end
    wait_done(0, 5, ok);
    vectors++;
    if (!ok || {done[0], pass_o[0], to_err[0], en[0], busy[0]} !== 5'b10100) begin
      miscompares++;
      $display("FAIL timeout_status: done=%b pass=%b to=%b en=%b busy=%b, required 1 0 1 0 0",
               done[0], pass_o[0], to_err[0], en[0], busy[0]);
    end
    stall_mode = 1'b0; model_reset;
  endtask

  task automatic test_addr_wrap;
    int base; bit ok;
    logic [23:0] exp_a [4];
    exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    sel = 1; model_reset; base = log_q.size();
    pulse_start; wait_done(1, 400, ok);
    for (int i = 0; i < 8 && base + i < log_q.size(); i++) begin
      vectors++;
      if (log_q[base+i].addr !== exp_a[i % 4]) begin
        miscompares++;
        $display("FAIL wrap_addr%0d: got %h, required %h", i, log_q[base+i].addr, exp_a[i % 4]);
      end
    end
    vectors++;
    if (log_q.size() > base && log_q[base].data !== 32'hA5FFFFFE) begin
      miscompares++; $display("FAIL wrap_data0: got %h, required a5fffffe", log_q[base].data);
    end
    vectors++;
    if (!ok || pass_o[1] !== 1'b1 || ec[1] !== 16'h0) begin
      miscompares++; $display("FAIL wrap_pass: done=%b pass=%b ec=%h, required 1 1 0000", done[1], pass_o[1], ec[1]);
    end
  endtask

  task automatic test_reset_mid;
    int base; bit ok;
    sel = 0; model_reset; base = log_q.size();
    pulse_start; wait_log(base + 13, 300, ok);
    @(negedge clk);
    vectors++;
    if (!ok || busy[0] !== 1'b1 || en[0] !== 1'b0 || log_q[base+12].wr !== 1'b0) begin
      miscompares++; $display("FAIL midreset_setup: busy=%b en=%b, required busy=1 en=0 in read wait", busy[0], en[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy[0], done[0], pass_o[0], to_err[0], en[0], wr[0]} !== 6'b0 ||
        addr[0] !== 24'h0 || wdat[0] !== 32'h0 || ec[0] !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_async: busy=%b en=%b wr=%b addr=%h, required all zero", busy[0], en[0], wr[0], addr[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset;
    pulse_start; wait_done(0, 400, ok);
    vectors++;
    if (!ok || pass_o[0] !== 1'b1 || ec[0] !== 16'h0 || to_err[0] !== 1'b0) begin
      miscompares++; $display("FAIL midreset_rerun: done=%b pass=%b ec=%h, required 1 1 0000", done[0], pass_o[0], ec[0]);
    end
  endtask

  task automatic test_saturate;
    int base; bit ok;
    sel = 2; zero_mode = 1'b1; model_reset; base = log_q.size();
    pulse_start; wait_log(base + 1, 50, ok);
    // Preload the counter near its ceiling so forty mismatches must saturate it.
    force u_dut_c.err_count = 16'hFFF0;
    @(negedge clk);
    release u_dut_c.err_count;
    repeat (200) @(negedge clk);
    pulse_start;
    vectors++;
    if (busy[2] !== 1'b1 || ec[2] < 16'hFFF0) begin
      miscompares++; $display("FAIL sat_start_ignored: busy=%b ec=%h, required busy=1 ec>=fff0", busy[2], ec[2]);
    end
    wait_done(2, 600, ok);
    zero_mode = 1'b0;
    vectors++;
    if (!ok || ec[2] !== 16'hFFFF || pass_o[2] !== 1'b0) begin
      miscompares++; $display("FAIL sat_count: done=%b ec=%h pass=%b, required 1 ffff 0", done[2], ec[2], pass_o[2]);
    end
    vectors++;
    if (log_q.size() - base !== 80 || fea[2] !== 24'h0) begin
      miscompares++;
      $display("FAIL sat_txns: txns=%0d first_addr=%h, required 80 000000", log_q.size() - base, fea[2]);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; start = 1'b0; sel = 0; m_clr = 1'b1;
    stall_mode = 1'b0; stuck_mode = 1'b0; zero_mode = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1; m_clr = 1'b0;
    @(negedge clk);
    test_clean;
    test_stuck_bit;
    test_timeout;
    test_addr_wrap;
    test_reset_mid;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
